binary_to_ternary_converter: RTL
================================

# binary_to_ternary_converter

Sequential converter that turns a W-bit unsigned binary operand into an N-trit, 2-bit-per-trit ternary word. Its output feeds the `a`/`b` operand inputs of the ternary carry-lookahead adder. It produces one trit per cycle by repeated division by three, uses valid/ready handshakes on both sides, and flags operands that do not fit in N trits.

## Interface
- `N`, default 4: number of output trits; output width is 2·N.
- `W`, default 6: binary input width; any W ≥ 2 is legal.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `inValid` in 1: `binIn` is valid.
- `inReady` out 1: converter can accept an operand.
- `binIn` in W: unsigned binary operand.
- `outValid` out 1: `trits` and `overflow` are valid.
- `outReady` in 1: consumer accepts the result.
- `trits` out 2·N: trit i occupies bits [2i+1:2i].
- `overflow` out 1: operand ≥ 3^N; `trits` then holds the operand mod 3^N.

## Operation
- Trit encoding: 00 = 0, 01 = 1, 10 = 2. The code 11 is never produced.
- States:
  - IDLE: `inReady` = 1. On `inValid`, load `binIn` into the quotient register, clear the trit register, set the digit counter to 0, and go to CONVERT.
  - CONVERT: each cycle, quotient ← quotient / 3. The remainder is written to trit[counter], and the counter increments. After the trit with index N−1 is written, set `overflow` = (quotient after division ≠ 0) and go to DONE.
  - DONE: `outValid` = 1. On `outReady`, go to IDLE.
- `inReady` is high only in IDLE. There is no accept in DONE, so a new conversion starts only after the previous result has been taken.
- `trits` and `overflow` are registered and held stable throughout DONE.
- In IDLE and CONVERT, `trits` holds the last completed result. It updates only on entry to DONE.
- `inValid` or `binIn` changing outside IDLE is ignored.
- Reset values: state IDLE, `inReady` = 1, `outValid` = 0, `trits` = all 0, `overflow` = 0, quotient = 0, counter = 0.
- Reset asserted mid-conversion aborts the conversion immediately. The partial result is discarded and never presented.

## Timing
- Accept edge = rising edge with IDLE ∧ `inValid`.
- Latency without early exit: `outValid` rises exactly N cycles after the accept edge.
- Handoff: result accepted on the edge with DONE ∧ `outReady`. `inReady` is high in the following cycle.
- Minimum issue interval: N + 2 cycles.
- `outValid` stays high with `trits` unchanged for as long as `outReady` is low.

## Configuration
- `TERNARY_CONV_EARLY_EXIT_EN`
  - Defined: CONVERT also exits to DONE when the post-division quotient is 0. Remaining high trits stay 00 and `overflow` = 0. Latency = max(1, number of significant trits); operand 0 takes 1 cycle.
  - Undefined: always N CONVERT cycles.
- Results are bit-identical either way; only latency differs.

## Structure
- Shared package holds:
  - trit constants `TRIT_0`, `TRIT_1`, `TRIT_2` (2-bit);
  - the state encoding (IDLE, CONVERT, DONE, 2-bit);
  - a `tritToInt` helper for benches.
- Sub-module `div_by_three` (combinational):
  - W-bit dividend → W-bit quotient and a 2-bit trit-encoded remainder;
  - built as an MSB-first restoring chain whose partial remainder is always < 3;
  - instantiated once.
- Counter width: clog2(N + 1).

## Test plan
- N=4, W=6, `binIn` = 5, `outReady` held high → `outValid` 4 cycles after accept; `trits` = 8'b00000110; `overflow` = 0.
- `binIn` = 63 → `trits` = 8'b10010000 (ternary 2100); `overflow` = 0.
- N=3, W=6, `binIn` = 27 → `trits` = 6'b000000; `overflow` = 1.
- `binIn` = 0 with `TERNARY_CONV_EARLY_EXIT_EN` → `outValid` 1 cycle after accept; `trits` = 0. Without the macro → 4 cycles.
- `binIn` = 40, `outReady` low for 5 cycles in DONE → `trits` = 8'b01010101 held stable and `inReady` = 0 throughout. `inValid` pulses during that window are ignored.
- `rst` pulsed 2 cycles after accepting 50 → `outValid` = 0 and `trits` = 0 immediately. Next operand 7 converts cleanly to 8'b00001001.

Source files
------------

// File: rtl/binary_to_ternary_converter_pkg.sv
// Shared definitions for the binary-to-ternary converter: trit codes, FSM states
// and a trit decode helper.
package binary_to_ternary_converter_pkg;

  localparam logic [1:0] TRIT_0 = 2'b00;
  localparam logic [1:0] TRIT_1 = 2'b01;
  localparam logic [1:0] TRIT_2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONVERT = 2'b01,
    DONE    = 2'b10
  } state_t;

  // Returns -1 for the illegal code 11.
  function automatic int tritToInt(input logic [1:0] t);
    case (t)
      TRIT_0:  return 0;
      TRIT_1:  return 1;
      TRIT_2:  return 2;
      default: return -1;
    endcase
  endfunction

endpackage

// File: rtl/binary_to_ternary_converter_div_by_three.sv
// Combinational divide-by-three: MSB-first restoring chain; the partial remainder
// stays below 3, so it is directly a trit code.
module div_by_three
  import binary_to_ternary_converter_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] dividend,
  output logic [W-1:0] quotient,
  output logic [1:0]   remainder
);

  logic [1:0] rem;
  logic [2:0] part;

  always_comb begin
    rem      = TRIT_0;
    part     = '0;
    quotient = '0;
    for (int i = W - 1; i >= 0; i--) begin
      part = {rem, dividend[i]};
      if (part >= 3'd3) begin
        quotient[i] = 1'b1;
        rem         = 2'(part - 3'd3);
      end else begin
        rem = part[1:0];
      end
    end
    remainder = rem;
  end

endmodule

// File: rtl/binary_to_ternary_converter.sv
// Sequential binary-to-ternary converter producing one trit per cycle by repeated /3.
// Optional TERNARY_CONV_EARLY_EXIT_EN stops as soon as the quotient reaches zero.
module binary_to_ternary_converter
  import binary_to_ternary_converter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inValid,
  output logic           inReady,
  input  logic [W-1:0]   binIn,
  output logic           outValid,
  input  logic           outReady,
  output logic [2*N-1:0] trits,
  output logic           overflow
);

  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_nxt;
  logic [W-1:0]     quot;
  logic [CW-1:0]    cnt;
  logic [2*N-1:0]   acc, acc_nxt;
  logic [W-1:0]     div_q;
  logic [1:0]       div_r;
  logic             zero_exit;
  logic             last;

  div_by_three #(.W(W)) u_div (
    .dividend (quot),
    .quotient (div_q),
    .remainder(div_r)
  );

`ifdef TERNARY_CONV_EARLY_EXIT_EN
  assign zero_exit = (div_q == '0);
`else
  assign zero_exit = 1'b0;
`endif

  assign last = (cnt == LAST) || zero_exit;

  // Accumulator with the current remainder dropped into slot cnt.
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) acc_nxt[2*i +: 2] = div_r;
    end
  end

  always_comb begin
    state_nxt = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) state_nxt = CONVERT;
      end
      CONVERT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Published result only changes on entry to DONE, so it holds through IDLE/CONVERT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot     <= '0;
      cnt      <= '0;
      acc      <= '0;
      trits    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            quot <= binIn;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        CONVERT: begin
          quot <= div_q;
          acc  <= acc_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            trits    <= acc_nxt;
            overflow <= (div_q != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
